// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

    // Frame position of the transmitter; each state covers one or more whole bit periods.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest word the transmitter supports; narrower words are zero-extended for parity.
    localparam int MAX_DATA_BITS = 9;

    // Even parity makes the total count of ones even; odd parity makes it odd.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (odd == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: o_tick is high on the last clock of every CLKS_PER_BIT-clock bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tick;

    // Down-counter reloads at a restart or after reaching terminal count 0.
    always_comb begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (restart || (r_cnt == '0)) begin
            w_cnt_next = RELOAD;
        end
    end

    // Tick is registered alongside the count so it is high exactly while the count is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == '0);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// with a valid/ready upstream handshake and a registered TX line.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_tx_clk,
    input  logic                 i_tx_rst,
    input  logic                 i_tx_valid,
    input  logic [DATA_BITS-1:0] i_data_in,
    output logic                 o_tx_ready,
    output logic                 o_tx_data_out,
    output logic                 o_tx_data_done,
    output logic                 o_tx_busy
);

    localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic PAR_SEL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be within 5..9");
    end
    if ((PARITY_EN != 0) && (PARITY_EN != 1)) begin : g_bad_pen
        $error("uart_tx_frame: PARITY_EN must be 0 or 1");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_podd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [DATA_BITS-1:0]   r_data;
    logic [DATA_BITS-1:0]   w_data_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
    logic                   r_stop_cnt;
    logic                   w_stop_cnt_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_ready;
    logic                   w_ready_next;
    logic                   r_busy;
    logic                   w_busy_next;
    logic                   w_accept;
    logic                   w_restart;
    logic                   w_tick;
    logic                   w_parity;
    logic                   w_last_stop;

    assign w_accept    = i_tx_valid && r_ready;
    assign w_parity    = calc_parity(MAX_DATA_BITS'(r_data), PAR_SEL);
    assign w_last_stop = (r_stop_cnt == LAST_STOP);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (i_tx_clk),
        .rst_n  (i_tx_rst),
        .restart(w_restart),
        .o_tick (w_tick)
    );

    // Next-state and next-output decode; outputs are precomputed so they leave flops directly.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_data_next     = r_data;
        w_bit_cnt_next  = r_bit_cnt;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = r_tx;
        w_ready_next    = r_ready;
        w_busy_next     = r_busy;
        w_restart       = 1'b0;

        case (r_state)
            IDLE: begin
                w_ready_next = 1'b1;
                if (w_accept) begin
                    w_state_next    = START;
                    w_shift_next    = i_data_in;
                    w_data_next     = i_data_in;
                    w_bit_cnt_next  = '0;
                    w_stop_cnt_next = 1'b0;
                    w_tx_next       = 1'b0;
                    w_ready_next    = 1'b0;
                    w_busy_next     = 1'b1;
                    w_restart       = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = '0;
                    w_tx_next      = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_state_next = PARITY;
                            w_tx_next    = w_parity;
                        end else begin
                            w_state_next    = STOP;
                            w_stop_cnt_next = 1'b0;
                            w_tx_next       = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
                        w_tx_next      = w_shift_next[0];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next    = STOP;
                    w_stop_cnt_next = 1'b0;
                    w_tx_next       = 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_state_next = IDLE;
                        w_ready_next = 1'b1;
                        w_busy_next  = 1'b0;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
                w_ready_next = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_tx_clk or negedge i_tx_rst) begin
        if (!i_tx_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and output registers; reset drops any frame in flight and idles the line high.
    always_ff @(posedge i_tx_clk or negedge i_tx_rst) begin
        if (!i_tx_rst) begin
            r_shift    <= '0;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_shift    <= w_shift_next;
            r_data     <= w_data_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_ready    <= w_ready_next;
            r_busy     <= w_busy_next;
        end
    end

    assign o_tx_ready     = r_ready;
    assign o_tx_data_out  = r_tx;
    assign o_tx_busy      = r_busy;
    assign o_tx_data_done = (r_state == STOP) && w_last_stop && w_tick;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: four parameter sets driven from a shared clock and reset,
// checked cycle by cycle against a frame model built from the serial-format rules.
module tb_uart_tx_frame;

    typedef struct {
        int cpb;
        int dbits;
        int pen;
        int podd;
        int sbits;
    } cfg_t;

    typedef struct {
        int         dut;
        logic [8:0] data;
        int         hasPar;
        logic       expPar;
        int         expDoneAt;
    } vec_t;

    localparam int CPB0 = 16, DB0 = 8, PEN0 = 1, POD0 = 0, SB0 = 1;
    localparam int CPB1 = 16, DB1 = 8, PEN1 = 1, POD1 = 1, SB1 = 1;
    localparam int CPB2 = 16, DB2 = 7, PEN2 = 0, POD2 = 0, SB2 = 2;
    localparam int CPB3 = 3,  DB3 = 9, PEN3 = 1, POD3 = 0, SB3 = 2;

    logic       clock = 1'b0;
    logic       rstN;
    logic [3:0] valid;
    logic [8:0] din [4];
    logic [3:0] line;
    logic [3:0] ready;
    logic [3:0] busy;
    logic [3:0] done;

    cfg_t       cfg [4];
    vec_t       vecs [4];
    logic [3:0] expQ [$];
    logic       obsLine [$];
    int         total = 0;
    int         bad = 0;

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    uart_tx_frame #(.CLKS_PER_BIT(CPB0), .DATA_BITS(DB0), .PARITY_EN(PEN0), .PARITY_ODD(POD0), .STOP_BITS(SB0)) dut0 (
        .i_tx_clk(clock), .i_tx_rst(rstN), .i_tx_valid(valid[0]), .i_data_in(din[0][DB0-1:0]),
        .o_tx_ready(ready[0]), .o_tx_data_out(line[0]), .o_tx_data_done(done[0]), .o_tx_busy(busy[0]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1), .PARITY_EN(PEN1), .PARITY_ODD(POD1), .STOP_BITS(SB1)) dut1 (
        .i_tx_clk(clock), .i_tx_rst(rstN), .i_tx_valid(valid[1]), .i_data_in(din[1][DB1-1:0]),
        .o_tx_ready(ready[1]), .o_tx_data_out(line[1]), .o_tx_data_done(done[1]), .o_tx_busy(busy[1]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB2), .DATA_BITS(DB2), .PARITY_EN(PEN2), .PARITY_ODD(POD2), .STOP_BITS(SB2)) dut2 (
        .i_tx_clk(clock), .i_tx_rst(rstN), .i_tx_valid(valid[2]), .i_data_in(din[2][DB2-1:0]),
        .o_tx_ready(ready[2]), .o_tx_data_out(line[2]), .o_tx_data_done(done[2]), .o_tx_busy(busy[2]));

    uart_tx_frame #(.CLKS_PER_BIT(CPB3), .DATA_BITS(DB3), .PARITY_EN(PEN3), .PARITY_ODD(POD3), .STOP_BITS(SB3)) dut3 (
        .i_tx_clk(clock), .i_tx_rst(rstN), .i_tx_valid(valid[3]), .i_data_in(din[3][DB3-1:0]),
        .o_tx_ready(ready[3]), .o_tx_data_out(line[3]), .o_tx_data_done(done[3]), .o_tx_busy(busy[3]));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic v, input logic [8:0] d);
        valid[k] = v;
        din[k]   = d;
    endtask

    function automatic int frameCycles(input int k);
        return (1 + cfg[k].dbits + cfg[k].pen + cfg[k].sbits) * cfg[k].cpb;
    endfunction

    // Expected {line,busy,done,ready} for every clock of one frame, built from the serial format.
    task automatic appendFrame(input int k, input logic [8:0] w);
        logic bits [$];
        int   ones;
        logic par;
        logic last;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < cfg[k].dbits; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (cfg[k].pen != 0) begin
            par = ((ones % 2) == 1);
            if (cfg[k].podd != 0) par = ~par;
            bits.push_back(par);
        end
        for (int i = 0; i < cfg[k].sbits; i++) bits.push_back(1'b1);
        for (int s = 0; s < bits.size(); s++) begin
            for (int c = 0; c < cfg[k].cpb; c++) begin
                last = (s == bits.size() - 1) && (c == cfg[k].cpb - 1);
                expQ.push_back({bits[s], 1'b1, last, 1'b0});
            end
        end
    endtask

    task automatic waitReady(input int k);
        int n;
        n = 0;
        while (ready[k] !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (ready[k] !== 1'b1) checkOutput($sformatf("dut%0d waitReady timeout", k), 32'd0, 32'd1);
    endtask

    // mode 0: single frame; mode 1: valid held for a second word; mode 2: inputs toggled while busy.
    task automatic sendFrame(input int k, input logic [8:0] w, input int mode, input logic [8:0] w2,
                             output int doneAt, output logic parObs);
        int         nc;
        logic [3:0] got;
        waitReady(k);
        nc = frameCycles(k);
        expQ.delete();
        obsLine.delete();
        appendFrame(k, w);
        expQ.push_back(4'b1001);
        if (mode == 1) begin
            appendFrame(k, w2);
            expQ.push_back(4'b1001);
        end
        if (mode == 2) expQ.push_back(4'b1001);
        applyStimulus(k, 1'b1, w);
        @(posedge clock);
        doneAt = -1;
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clock);
            got = {line[k], busy[k], done[k], ready[k]};
            checkOutput($sformatf("dut%0d word %0h cycle T+%0d {line,busy,done,ready}", k, w, i + 1),
                        32'(got), 32'(expQ[i]));
            if (done[k] === 1'b1 && doneAt < 0) doneAt = i + 1;
            obsLine.push_back(line[k]);
            case (mode)
                0: if (i == 0) applyStimulus(k, 1'b0, ~w);
                1: begin
                    if (i == 0) applyStimulus(k, 1'b1, w2);
                    if (i == nc + 1) applyStimulus(k, 1'b0, ~w2);
                end
                default: begin
                    if (i < nc) applyStimulus(k, 1'($urandom_range(0, 1)), 9'($urandom));
                    else applyStimulus(k, 1'b0, 9'h000);
                end
            endcase
        end
        parObs = (cfg[k].pen != 0) ? obsLine[(1 + cfg[k].dbits) * cfg[k].cpb + cfg[k].cpb / 2] : 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, table vectors, back-to-back, busy toggling, random words, reset mid-frame.
    initial begin
        int         doneAt;
        logic       parObs;
        int         k;
        int         mode;
        logic [8:0] w;
        int         doneCount;
        int         busyCount;

        cfg[0] = '{CPB0, DB0, PEN0, POD0, SB0};
        cfg[1] = '{CPB1, DB1, PEN1, POD1, SB1};
        cfg[2] = '{CPB2, DB2, PEN2, POD2, SB2};
        cfg[3] = '{CPB3, DB3, PEN3, POD3, SB3};

        vecs[0] = '{0, 9'h0A5, 1, 1'b0, 176};
        vecs[1] = '{1, 9'h000, 1, 1'b1, 176};
        vecs[2] = '{1, 9'h0FF, 1, 1'b1, 176};
        vecs[3] = '{2, 9'h07F, 0, 1'b0, 160};

        rstN  = 1'b0;
        valid = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = 9'h000;

        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("dut%0d reset {line,busy,done,ready}", i),
                        32'({line[i], busy[i], done[i], ready[i]}), 32'(4'b1000));
        rstN = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) checkOutput($sformatf("dut%0d ready at release", i), 32'(ready[i]), 32'd0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("dut%0d ready one clock after release", i), 32'(ready[i]), 32'd1);

        for (int v = 0; v < 4; v++) begin
            sendFrame(vecs[v].dut, vecs[v].data, 0, 9'h000, doneAt, parObs);
            checkOutput($sformatf("vec%0d done cycle", v), 32'(doneAt), 32'(vecs[v].expDoneAt));
            if (vecs[v].hasPar != 0)
                checkOutput($sformatf("vec%0d parity bit", v), 32'(parObs), 32'(vecs[v].expPar));
        end

        sendFrame(0, 9'h03C, 1, 9'h0C3, doneAt, parObs);
        checkOutput("back-to-back first done cycle", 32'(doneAt), 32'd176);

        sendFrame(0, 9'h069, 2, 9'h000, doneAt, parObs);
        sendFrame(3, 9'h1A6, 2, 9'h000, doneAt, parObs);

        for (int r = 0; r < 12; r++) begin
            k    = $urandom_range(0, 3);
            w    = 9'($urandom) & 9'((1 << cfg[k].dbits) - 1);
            mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
            sendFrame(k, w, mode, 9'h000, doneAt, parObs);
            checkOutput($sformatf("random%0d dut%0d done cycle", r, k), 32'(doneAt), 32'(frameCycles(k)));
        end

        waitReady(0);
        applyStimulus(0, 1'b1, 9'h052);
        @(posedge clock);
        for (int i = 0; i < 4 * CPB0 + 3; i++) begin
            @(negedge clock);
            if (i == 0) applyStimulus(0, 1'b0, 9'h000);
        end
        checkOutput("dut0 line during data bit 3", 32'(line[0]), 32'd0);
        checkOutput("dut0 busy during data bit 3", 32'(busy[0]), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("dut0 reset mid-frame {line,busy,done,ready}",
                    32'({line[0], busy[0], done[0], ready[0]}), 32'(4'b1000));
        doneCount = 0;
        busyCount = 0;
        repeat (2) begin
            @(negedge clock);
            if (done[0] === 1'b1) doneCount++;
        end
        rstN = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (done[0] === 1'b1) doneCount++;
            if (busy[0] === 1'b1) busyCount++;
        end
        checkOutput("dut0 done pulses after dropped frame", 32'(doneCount), 32'd0);
        checkOutput("dut0 busy cycles after dropped frame", 32'(busyCount), 32'd0);
        sendFrame(0, 9'h0B7, 0, 9'h000, doneAt, parObs);
        checkOutput("dut0 frame after reset done cycle", 32'(doneAt), 32'd176);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
